// File: rtl/seg7_pkg.sv
// Segment codes {a,b,c,d,e,f,g,dp} (a in bit 7) and the BCD-to-segment decoder
// shared by the fading seven-segment display blocks.
package seg7_pkg;

   localparam logic [3:0] BCD_MAX   = 4'd9;

   localparam logic [7:0] SEG_0     = 8'hFC;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hDA;
   localparam logic [7:0] SEG_3     = 8'hF2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hB6;
   localparam logic [7:0] SEG_6     = 8'hBE;
   localparam logic [7:0] SEG_7     = 8'hE0;
   localparam logic [7:0] SEG_8     = 8'hFE;
   localparam logic [7:0] SEG_9     = 8'hF6;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   function automatic logic [7:0] bcd_to_seg(input logic [3:0] i_bcd);
      case (i_bcd)
         4'd0:    return SEG_0;
         4'd1:    return SEG_1;
         4'd2:    return SEG_2;
         4'd3:    return SEG_3;
         4'd4:    return SEG_4;
         4'd5:    return SEG_5;
         4'd6:    return SEG_6;
         4'd7:    return SEG_7;
         4'd8:    return SEG_8;
         4'd9:    return SEG_9;
         default: return SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/bcd_counter_chain.sv
// DIGITS-wide decimal up/down counter with clamped synchronous load. Keeps the
// previous count in o_old so the display can cross-fade between the two.
module bcd_counter_chain
   import seg7_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_step,
   input  logic                i_up,
   input  logic                i_load,
   input  logic [4*DIGITS-1:0] i_load_val,
   output logic [4*DIGITS-1:0] o_value,
   output logic [4*DIGITS-1:0] o_old,
   output logic                o_wrap
);

   logic [4*DIGITS-1:0] r_value;
   logic [4*DIGITS-1:0] r_old;
   logic [4*DIGITS-1:0] w_next;
   logic [4*DIGITS-1:0] w_clamp;
   logic [DIGITS:0]     w_carry;

   // w_carry is a carry when counting up and a borrow when counting down;
   // a carry out of the top digit is exactly the wrap condition.
   always_comb begin
      w_next     = '0;
      w_clamp    = '0;
      w_carry    = '0;
      w_carry[0] = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         w_clamp[4*i +: 4] = (i_load_val[4*i +: 4] > BCD_MAX) ? 4'd0 : i_load_val[4*i +: 4];
         if (!w_carry[i]) begin
            w_next[4*i +: 4] = r_value[4*i +: 4];
            w_carry[i+1]     = 1'b0;
         end else if (i_up) begin
            w_carry[i+1]     = (r_value[4*i +: 4] == BCD_MAX);
            w_next[4*i +: 4] = w_carry[i+1] ? 4'd0 : r_value[4*i +: 4] + 4'd1;
         end else begin
            w_carry[i+1]     = (r_value[4*i +: 4] == 4'd0);
            w_next[4*i +: 4] = w_carry[i+1] ? BCD_MAX : r_value[4*i +: 4] - 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_value <= '0;
         r_old   <= '0;
      end else if (i_load) begin
         r_value <= w_clamp;
         r_old   <= w_clamp;
      end else if (i_step) begin
         r_old   <= r_value;
         r_value <= w_next;
      end
   end

   assign o_value = r_value;
   assign o_old   = r_old;
   assign o_wrap  = w_carry[DIGITS];

endmodule

// File: rtl/seven_seg_fade_scan.sv
// Multi-digit BCD counter with PWM cross-fade between old and new count,
// scanned onto a time-multiplexed seven-segment display.
module seven_seg_fade_scan
   import seg7_pkg::*;
#(
   parameter int DIGITS    = 4,
   parameter int TICK_BITS = 24,
   parameter int FADE_BITS = 4,
   parameter int SCAN_BITS = 16,
   parameter int BLANK_LZ  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                up,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   output logic [4*DIGITS-1:0] value,
   output logic                step,
   output logic                wrap,
   output logic [7:0]          seg,
   output logic [DIGITS-1:0]   dig_sel
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [TICK_BITS-1:0] r_presc;
   logic [FADE_BITS:0]   r_acc;
   logic [SCAN_BITS-1:0] r_sc;
   logic [IDX_W-1:0]     r_idx;
   logic                 r_step;
   logic                 r_wrap;
   logic [7:0]           r_seg;
   logic [DIGITS-1:0]    r_dig_sel;

   logic [4*DIGITS-1:0]  w_value;
   logic [4*DIGITS-1:0]  w_old;
   logic [4*DIGITS-1:0]  w_shown;
   logic [FADE_BITS-1:0] w_duty;
   logic [3:0]           w_dig;
   logic [DIGITS:0]      w_lz;
   logic                 w_tick;
   logic                 w_wrap;
   logic                 w_phase;
   logic                 w_show_new;
   logic                 w_blank;

   bcd_counter_chain #(.DIGITS(DIGITS)) u_chain (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_step     (w_tick),
      .i_up       (up),
      .i_load     (load),
      .i_load_val (load_val),
      .o_value    (w_value),
      .o_old      (w_old),
      .o_wrap     (w_wrap)
   );

   assign w_tick     = en && (&r_presc);
   assign w_phase    = r_presc[TICK_BITS-1];
   assign w_duty     = r_presc[TICK_BITS-2 -: FADE_BITS];
   // Accumulator carry is a first-order PWM of duty; the second half-period shows new outright.
   assign w_show_new = w_phase | r_acc[FADE_BITS];
   assign w_shown    = w_show_new ? w_value : w_old;

   // w_lz[i]: every shown digit from i upward is zero.
   always_comb begin
      w_dig        = 4'd0;
      w_blank      = 1'b0;
      w_lz         = '0;
      w_lz[DIGITS] = 1'b1;
      for (int i = DIGITS-1; i >= 0; i--) begin
         w_lz[i] = w_lz[i+1] && (w_shown[4*i +: 4] == 4'd0);
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_dig   = w_shown[4*i +: 4];
            w_blank = (BLANK_LZ != 0) && (i != 0) && w_lz[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc   <= '0;
         r_acc     <= '0;
         r_sc      <= '0;
         r_idx     <= '0;
         r_step    <= 1'b0;
         r_wrap    <= 1'b0;
         r_seg     <= SEG_BLANK;
         r_dig_sel <= '0;
      end else begin
         r_acc <= {1'b0, r_acc[FADE_BITS-1:0]} + {1'b0, w_duty};
         r_sc  <= r_sc + SCAN_BITS'(1);
         if (&r_sc) begin
            r_idx <= (r_idx == IDX_W'(DIGITS-1)) ? '0 : r_idx + IDX_W'(1);
         end
         if (load) begin
            r_presc <= '0;
         end else if (en) begin
            r_presc <= r_presc + TICK_BITS'(1);
         end
         r_step    <= w_tick && !load;
         r_wrap    <= w_tick && !load && w_wrap;
         r_seg     <= w_blank ? SEG_BLANK : bcd_to_seg(w_dig);
         r_dig_sel <= DIGITS'(1) << r_idx;
      end
   end

   assign value   = w_value;
   assign step    = r_step;
   assign wrap    = r_wrap;
   assign seg     = r_seg;
   assign dig_sel = r_dig_sel;

endmodule

// File: doc/seven_seg_fade_scan.md
# seven_seg_fade_scan

Parametrised multi-digit BCD counter with cross-faded digit transitions and a time-multiplexed seven-segment driver. It is the next generation of the single-digit 0–9 fading counter used on the Mojo top level. It adds the following:
- N digits with ripple carry.
- Up/down counting.
- Synchronous load.
- Digit scanning.
- Optional leading-zero blanking.

It sits between `mojo_top` and the board LED or display pins.

## Interface
Parameters:
- `DIGITS`, 4: number of BCD digits, 1..8.
- `TICK_BITS`, 24: prescaler width; one count step every 2^TICK_BITS clocks; minimum FADE_BITS+2.
- `FADE_BITS`, 4: PWM resolution of the cross-fade.
- `SCAN_BITS`, 16: scan prescaler width; each digit is shown for 2^SCAN_BITS clocks.
- `BLANK_LZ`, 0: 1 blanks leading zero digits; digit 0 (least significant) is never blanked.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst_n`  in  1: reset. One clock; reset is synchronous and active-low.
- `en`  in  1: count enable; the prescaler holds while low.
- `up`  in  1: 1 counts up, 0 counts down; sampled on the step cycle.
- `load`  in  1: single-cycle load strobe.
- `load_val`  in  4*DIGITS: BCD load value; digit i is bits [4i+3:4i].
- `value`  out  4*DIGITS: current (new) count.
- `step`  out  1: one-cycle pulse on each count step.
- `wrap`  out  1: one-cycle pulse coincident with `step` when the count wraps.
- `seg`  out  8: segments {a,b,c,d,e,f,g,dp}, active-high, a in bit 7; dp is always 0.
- `dig_sel`  out  DIGITS: one-hot active-high digit enable.

## Operation
- **Prescaler.** `presc` has TICK_BITS bits and increments while `en`=1. A step occurs on the cycle `presc` is all-ones and `en`=1.
- **Step.**
  - `old` <= `value`.
  - `value` <= `value`±1 with decimal ripple carry per digit.
  - Counting up, 9…9 wraps to 0…0. Counting down, 0…0 wraps to 9…9. Both wraps assert `wrap`.
- **Load.**
  - Sets `value` and `old` to `load_val`, with no fade.
  - Clears `presc`.
  - Any digit greater than 9 in `load_val` is loaded as 0.
  - `load` has priority over a simultaneous step; `step` and `wrap` stay 0 on that cycle.
- **Fade.**
  - `phase` = `presc`[TICK_BITS-1]. `duty` = `presc`[TICK_BITS-2 -: FADE_BITS].
  - First-order accumulator: `acc` (FADE_BITS+1 bits) <= `acc`[FADE_BITS-1:0] + `duty`, every clock.
  - Shown value = `value` if (`phase` | `acc`[FADE_BITS]), else `old`.
  - The brightness of the new digit therefore ramps 0→(2^F−1)/2^F over the first half-period, then holds fully on.
- **Scan.**
  - `sc` (SCAN_BITS bits) free-runs. `idx` advances 0→DIGITS-1→0 on each `sc` all-ones.
  - The active digit is shown-value digit `idx`.
- **Decode, registered.** Digits 0–9 map to:
  - 0: FC
  - 1: 60
  - 2: DA
  - 3: F2
  - 4: 66
  - 5: B6
  - 6: BE
  - 7: E0
  - 8: FE
  - 9: F6
  - Anything else decodes to 00.
- **Blanking.** With BLANK_LZ=1, digit i > 0 shows `seg`=00 when all shown digits i..DIGITS-1 are 0. `dig_sel` is still driven for that digit.

## Timing
- **Reset** (`rst_n` low at a clk edge):
  - State cleared: `presc`, `sc`, `idx`, `acc`, `value` and `old` = 0.
  - Outputs: `seg`=00, `dig_sel`=0, `step`=`wrap`=0.
  - First cycle after release: `dig_sel`=1 and `seg`=FC (digit 0 showing 0).
- **Reset mid-fade** aborts the fade; no partial state survives.
- **`step` and `wrap`** are registered and assert on the cycle after `presc`=all-ones. `value` updates on that same edge.
- **Load latency:** `value` reflects `load_val` one cycle after `load`.
- **`seg` and `dig_sel`** are registered and change together one cycle after `idx` or the shown value changes. `dig_sel` is never multi-hot.
- **`en` deasserted mid-fade** freezes `presc`, so the partially blended display holds until `en` returns.
- **`up` changing between steps** affects only the next step.

## Structure
- Package `seg7_pkg` holds:
  - the segment-code constants SEG_0..SEG_9 and SEG_BLANK;
  - the function `bcd_to_seg`.
- Sub-module `bcd_counter_chain` holds the DIGITS-wide up/down decimal counter with load, clamp and wrap.
- Prescaler, fade, scan and decode stay in the top block.

## Test plan
For simulation: TICK_BITS=6, FADE_BITS=2, SCAN_BITS=2, DIGITS=2.
1. **Reset.** Hold `rst_n`=0 for 3 clocks, then release → during reset `seg`=00 and `dig_sel`=00; first cycle after release `dig_sel`=01 and `seg`=FC.
2. **Up-count wrap.** Load 0x99 with `en`=1 and `up`=1 → after 64 clocks `value`=0x00 and `step`=`wrap`=1 for exactly one cycle.
3. **Down-count wrap.** Load 0x00 with `up`=0 → next step gives `value`=0x99 and `wrap`=1.
4. **Load clamp and priority.** Assert `load`, `load_val`=0xA7, on the step cycle → `value`=0x07, `old`=0x07, `step`=0.
5. **Fade.** Load 0x04, then step to 0x05. Over the first 32 clocks, count the cycles in which digit 0 selects `value` → the counts per 8-clock duty slot are 0, 2, 4, 6 (±1). For the next 32 clocks digit 0 always shows `seg`=B6.
6. **Blanking.** With BLANK_LZ=1 and `value`=0x07 → during `dig_sel`=10, `seg`=00; during `dig_sel`=01, `seg`=E0.
